// File: rtl/demux_stream_1_n.sv
// demux_stream_1_n: one-word holding stage that delivers each input word to
// a single output channel (unicast) or to every channel (broadcast).
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   D          input data word
//   S          destination channel index (ignored when bcast=1)
//   bcast      deliver the word to all N channels
//   in_valid   D/S/bcast are valid
//   in_ready   a word is accepted this cycle
//   Y          held data word, shared by all channels
//   out_valid  per-channel offer mask (equals the pending mask)
//   out_ready  per-channel accept mask
//   err        one-cycle pulse after a word is dropped for an illegal select
//   drop_cnt   saturating count of dropped words
module demux_stream_1_n #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] D,
  input  logic [SEL_W-1:0]  S,
  input  logic              bcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] Y,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic              err,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [0:0] {StEmpty, StBusy} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        pending_q, pending_d;
  logic [N-1:0]        sel_onehot;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                sel_legal;
  logic                accept;

  // Decode S; an all-zero result means S >= N and the word must be dropped.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (S == SEL_W'(k)) sel_onehot[k] = 1'b1;
    end
  end

  assign sel_legal = |sel_onehot;

  // Ready as soon as every still-pending channel is taking the word this
  // cycle, so a new word can follow the last delivery with no bubble.
  assign in_ready = (state_q == StEmpty) || ((pending_q & ~out_ready) == '0);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    y_d       = y_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    if (state_q == StBusy) pending_d = pending_q & ~out_ready;

    if (accept) begin
      if (bcast) begin
        pending_d = '1;
        y_d       = D;
      end else if (sel_legal) begin
        pending_d = sel_onehot;
        y_d       = D;
      end else begin
        // Dropped word: pending and Y keep their (already cleared) values.
        err_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end

    state_d = (pending_d != '0) ? StBusy : StEmpty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      y_q       <= '0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = pending_q;
  assign err       = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_stream_1_n.sv
module tb_demux_stream_1_n;

  logic       clk;
  logic       rst_n;

  // N=4 instance
  logic [7:0] d;
  logic [1:0] s;
  logic       bcast;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       err;
  logic [7:0] drop_cnt;

  // N=3 instance, used for illegal selects
  logic [7:0] b_d;
  logic [1:0] b_s;
  logic       b_bcast;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_y;
  logic [2:0] b_out_valid;
  logic [2:0] b_out_ready;
  logic       b_err;
  logic [7:0] b_drop_cnt;

  int total;
  int bad;

  demux_stream_1_n #(.DATA_W(8), .N(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D         (d),
    .S         (s),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .drop_cnt  (drop_cnt)
  );

  demux_stream_1_n #(.DATA_W(8), .N(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .D         (b_d),
    .S         (b_s),
    .bcast     (b_bcast),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .Y         (b_y),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .err       (b_err),
    .drop_cnt  (b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    d = 8'h00; s = 2'd0; bcast = 1'b0; in_valid = 1'b0; out_ready = 4'h0;
    b_d = 8'h00; b_s = 2'd0; b_bcast = 1'b0; b_in_valid = 1'b0; b_out_ready = 3'b111;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    #9 rst_n = 1'b1;   // released at t=12, away from the edge at t=15
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'h0);

    // Unicast sweep, one word per cycle
    out_ready = 4'hF; in_valid = 1'b1; d = 8'hA5; bcast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      chk($sformatf("uni_in_ready_%0d", i), 32'(in_ready), 32'h1);
      tick();
      chk($sformatf("uni_out_valid_%0d", i), 32'(out_valid), 32'h1 << i);
      chk($sformatf("uni_y_%0d", i), 32'(y), 32'hA5);
    end
    in_valid = 1'b0;
    tick();
    chk("uni_drain", 32'(out_valid), 32'h0);

    // Broadcast with staggered ready
    out_ready = 4'h0; in_valid = 1'b1; d = 8'h3C; bcast = 1'b1;
    tick();
    in_valid = 1'b0; bcast = 1'b0;
    chk("bc_ov0", 32'(out_valid), 32'hF);
    chk("bc_y", 32'(y), 32'h3C);
    out_ready = 4'b0001; #1;
    chk("bc_rdy1", 32'(in_ready), 32'h0);
    tick();
    chk("bc_ov1", 32'(out_valid), 32'hE);
    out_ready = 4'b0110; #1;
    chk("bc_rdy2", 32'(in_ready), 32'h0);
    tick();
    chk("bc_ov2", 32'(out_valid), 32'h8);
    out_ready = 4'b1000; #1;
    chk("bc_rdy3", 32'(in_ready), 32'h1);
    tick();
    chk("bc_ov3", 32'(out_valid), 32'h0);
    chk("bc_y_hold_empty", 32'(y), 32'h3C);

    // Backpressure on channel 2
    out_ready = 4'h0; in_valid = 1'b1; d = 8'h11; s = 2'd2;
    tick();
    chk("bp_ov_load", 32'(out_valid), 32'h4);
    d = 8'h22; s = 2'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rdy_%0d", i), 32'(in_ready), 32'h0);
      tick();
      chk($sformatf("bp_ov_%0d", i), 32'(out_valid), 32'h4);
      chk($sformatf("bp_y_%0d", i), 32'(y), 32'h11);
    end
    out_ready = 4'b0100; #1;
    chk("bp_rdy_release", 32'(in_ready), 32'h1);
    tick();
    chk("bp_ov_new", 32'(out_valid), 32'h1);
    chk("bp_y_new", 32'(y), 32'h22);
    in_valid = 1'b0; out_ready = 4'hF;
    tick();
    chk("bp_drain", 32'(out_valid), 32'h0);

    // Last bit clears in the same cycle a new word (S=1) is accepted
    out_ready = 4'h0; in_valid = 1'b1; d = 8'h55; s = 2'd3;
    tick();
    chk("sim_ov_load", 32'(out_valid), 32'h8);
    d = 8'h66; s = 2'd1; out_ready = 4'b1000; #1;
    chk("sim_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("sim_ov", 32'(out_valid), 32'h2);
    chk("sim_y", 32'(y), 32'h66);
    in_valid = 1'b0; out_ready = 4'hF;
    tick();

    // Illegal select on the N=3 instance; the legal word first sets Y
    b_in_valid = 1'b1; b_d = 8'h9A; b_s = 2'd0;
    tick();
    chk("ill_legal_ov", 32'(b_out_valid), 32'h1);
    b_d = 8'hFF; b_s = 2'd3; #1;
    chk("ill_rdy", 32'(b_in_ready), 32'h1);
    tick();
    chk("ill_err", 32'(b_err), 32'h1);
    chk("ill_cnt1", 32'(b_drop_cnt), 32'h1);
    chk("ill_ov", 32'(b_out_valid), 32'h0);
    chk("ill_y_kept", 32'(b_y), 32'h9A);
    b_in_valid = 1'b0;
    tick();
    chk("ill_err_pulse", 32'(b_err), 32'h0);
    chk("ill_cnt_hold", 32'(b_drop_cnt), 32'h1);
    b_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    b_in_valid = 1'b0;
    tick();
    chk("ill_cnt_sat", 32'(b_drop_cnt), 32'hFF);
    chk("ill_ov_after", 32'(b_out_valid), 32'h0);

    // Reset mid-broadcast
    out_ready = 4'h0; in_valid = 1'b1; d = 8'h77; bcast = 1'b1;
    tick();
    in_valid = 1'b0; bcast = 1'b0;
    chk("mr_ov_pre", 32'(out_valid), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("mr_ov", 32'(out_valid), 32'h0);
    chk("mr_y", 32'(y), 32'h0);
    chk("mr_rdy", 32'(in_ready), 32'h1);
    chk("mr_cnt", 32'(b_drop_cnt), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("mr_ov_after", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_stream_1_n.md
DEMUX_STREAM_1_N -- requirements
Module: demux_stream_1_n

Interface
REQ-001 Parameter DATA_W, default 8: data width in bits; legal range is 1 or more.
REQ-002 Parameter N, default 4: number of output channels; legal range is 2 to 16.
REQ-003 Parameter SEL_W, default 2: select width, SHALL equal ceil(log2(N)).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port D, input, DATA_W bits: input data word.
REQ-007 Port S, input, SEL_W bits: destination channel index.
REQ-008 Port bcast, input, 1 bit: when 1, the word is delivered to all N channels and S is ignored.
REQ-009 Port in_valid, input, 1 bit: D, S and bcast are valid.
REQ-010 Port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-011 Port Y, output, DATA_W bits: held data word, shared by all channels.
REQ-012 Port out_valid, output, N bits: bit k = Y is offered to channel k.
REQ-013 Port out_ready, input, N bits: bit k = channel k accepts.
REQ-014 Port err, output, 1 bit: one-cycle pulse when a word is dropped for an illegal select.
REQ-015 Port drop_cnt, output, 8 bits: saturating count of dropped words.

Function
REQ-016 Input transfer: in_valid=1 and in_ready=1 on a rising edge.
REQ-017 Output transfer on channel k: out_valid[k]=1 and out_ready[k]=1 on a rising edge.
REQ-018 State: 1-entry holding register (Y) plus an N-bit pending mask; out_valid SHALL equal pending.
REQ-019 States:
- EMPTY: pending==0.
- BUSY: pending!=0.
- EMPTY->BUSY on an accepted legal word.
- BUSY->EMPTY when the last pending bit is cleared and no new word is accepted in that cycle.
REQ-020 Accepted word with bcast=1: pending SHALL load all ones and Y SHALL load D on the same edge.
REQ-021 Accepted word with bcast=0 and S<N: pending SHALL load the one-hot value 1<<S and Y SHALL load D.
REQ-022 Accepted word with bcast=0 and S>=N: the word is dropped; pending and Y are unchanged, err=1 for the next cycle, and drop_cnt increments, saturating at 255.
REQ-023 Each cycle in BUSY, pending SHALL clear the bits where out_ready=1; channels may complete in different cycles.
REQ-024 in_ready SHALL equal (pending & ~out_ready)==0.
- This is a combinational path from out_ready and permits back-to-back words with no bubble.
REQ-025 When the last pending bit clears and a new word is accepted in the same cycle, the new word SHALL load pending and Y; latency from accept to out_valid is 1 cycle.
REQ-026 Y SHALL stay stable while any pending bit is set; out_valid bits SHALL NOT drop without the matching out_ready.
REQ-027 Y SHALL hold its last value in EMPTY.
REQ-028 A dropped word SHALL count as accepted: in_ready follows REQ-024 regardless of S.

Reset
REQ-029 rst_n=0 SHALL asynchronously force pending=0, Y=0, err=0 and drop_cnt=0, giving out_valid=0 and in_ready=1.
REQ-030 Reset asserted mid-broadcast SHALL discard the pending word with no further out_valid.
REQ-031 Deassertion SHALL be synchronised by the user; the first transfer is allowed on the first edge after rst_n=1.

Verification
REQ-032 Unicast sweep (N=4, DATA_W=8), for S=0..3:
- Stimulus: D=8'hA5, bcast=0, out_ready=4'hF.
- Response: out_valid = 0001, 0010, 0100, 1000 in turn, Y=A5, one word per cycle.
REQ-033 Broadcast with staggered ready:
- Stimulus: D=8'h3C, bcast=1, then out_ready=0001, 0110, 1000 on successive cycles.
- Response: out_valid = 1111, 1110, 1000, then 0000; in_ready=1 only in the third cycle.
REQ-034 Backpressure:
- Stimulus: S=2, out_ready=0 for 5 cycles, with a new word presented.
- Response: Y and out_valid=0100 held, in_ready=0; the new word is accepted on the cycle out_ready[2]=1.
REQ-035 Illegal select:
- Stimulus: N=3, S=3, bcast=0.
- Response: err pulses one cycle, drop_cnt=1, out_valid stays 000.
- Stimulus: 300 illegal words.
- Response: drop_cnt=255.
REQ-036 Reset mid-operation:
- Stimulus: rst_n=0 while out_valid=1111.
- Response: immediately out_valid=0000, Y=0, drop_cnt=0, in_ready=1.
REQ-037 Simultaneous events:
- Stimulus: last pending bit cleared in the same cycle as a new accept (S=1).
- Response: next cycle out_valid=0010 with the new Y, and no idle cycle.
